// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the VRAM time-slot arbiters: slot owner and CPU handshake states.
package vram_arbiter_pkg;

    localparam int unsigned VRAM_AW = 13;
    localparam int unsigned VRAM_DW = 8;
    localparam int unsigned HPOS_W  = 9;

    typedef enum logic {
        SLOT_VIDEO = 1'b0,
        SLOT_CPU   = 1'b1
    } slot_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } cpu_state_e;

    // Even pixels of the active line belong to the fetcher; everything else to the CPU.
    function automatic slot_e slot_owner(input logic blank, input logic hpos_odd);
        return (!blank && !hpos_odd) ? SLOT_VIDEO : SLOT_CPU;
    endfunction

endpackage

// File: rtl/vram_arbiter.sv
// Shares one single-port VRAM between the tile fetcher (even active pixels)
// and the Z80 bus (odd pixels and blanking) with a wait-state handshake.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int unsigned AW = VRAM_AW,
    parameter int unsigned DW = VRAM_DW
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              PCLK_EN,
    input  logic [HPOS_W-1:0] HPOS,
    input  logic              BLANK,
    input  logic [AW-1:0]     VID_AD,
    output logic [DW-1:0]     VID_DT,
    output logic              VID_RDY,
    input  logic              CPU_CS,
    input  logic              CPU_WR,
    input  logic [AW-1:0]     CPU_AD,
    input  logic [DW-1:0]     CPU_DI,
    output logic [DW-1:0]     CPU_DO,
    output logic              CPU_WAIT,
    output logic [AW-1:0]     RAM_AD,
    output logic              RAM_WE,
    output logic [DW-1:0]     RAM_DO,
    input  logic [DW-1:0]     RAM_DI
);

    cpu_state_e state;
    cpu_state_e state_nxt;
    slot_e      slot_c;
    logic       grant_c;
    logic       acc_end_c;
    logic       vid_pend;
    logic       unused_c;

    assign slot_c   = slot_owner(BLANK, HPOS[0]);
    assign unused_c = ^HPOS[HPOS_W-1:1];

    // Wait must be visible in the very first cycle of a request.
    assign CPU_WAIT = CPU_CS && (state != DONE);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A request that arrives in a CPU slot is granted at once; otherwise it parks in PEND.
    always_comb begin
        state_nxt = state;
        grant_c   = 1'b0;
        acc_end_c = 1'b0;
        if (PCLK_EN) begin
            case (state)
                IDLE: begin
                    if (CPU_CS) begin
                        if (slot_c == SLOT_CPU) begin
                            grant_c   = 1'b1;
                            state_nxt = ACC;
                        end else begin
                            state_nxt = PEND;
                        end
                    end
                end
                PEND: begin
                    if (slot_c == SLOT_CPU) begin
                        grant_c   = 1'b1;
                        state_nxt = ACC;
                    end
                end
                ACC: begin
                    acc_end_c = 1'b1;
                    state_nxt = DONE;
                end
                DONE: begin
                    if (!CPU_CS) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            vid_pend <= 1'b0;
            VID_DT   <= '0;
            VID_RDY  <= 1'b0;
            CPU_DO   <= '0;
            RAM_AD   <= '0;
            RAM_WE   <= 1'b0;
            RAM_DO   <= '0;
        end else begin
            VID_RDY <= 1'b0;
            if (PCLK_EN) begin
                if (vid_pend) begin
                    VID_DT  <= RAM_DI;
                    VID_RDY <= 1'b1;
                end
                vid_pend <= (slot_c == SLOT_VIDEO);
                RAM_WE   <= 1'b0;
                if (slot_c == SLOT_VIDEO) begin
                    RAM_AD <= VID_AD;
                end else if (grant_c) begin
                    RAM_AD <= CPU_AD;
                    RAM_DO <= CPU_DI;
                    RAM_WE <= CPU_WR;
                end
                // RAM_WE still high here means the finishing access was a write.
                if (acc_end_c && !RAM_WE) begin
                    CPU_DO <= RAM_DI;
                end
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous VRAM and a 1-in-4 pixel clock.
module tb_vram_arbiter;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 8;

    logic          CLK;
    logic          RESET_N;
    logic          PCLK_EN;
    logic [8:0]    HPOS;
    logic          BLANK;
    logic [AW-1:0] VID_AD;
    logic [DW-1:0] VID_DT;
    logic          VID_RDY;
    logic          CPU_CS;
    logic          CPU_WR;
    logic [AW-1:0] CPU_AD;
    logic [DW-1:0] CPU_DI;
    logic [DW-1:0] CPU_DO;
    logic          CPU_WAIT;
    logic [AW-1:0] RAM_AD;
    logic          RAM_WE;
    logic [DW-1:0] RAM_DO;
    logic [DW-1:0] RAM_DI;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            we_cnt = 0;
    int            n_pass = 0;
    int            n_total = 0;
    int            vid_base = 0;
    logic          prev_vid;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] exp_vid_dt;

    vram_arbiter dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .PCLK_EN  (PCLK_EN),
        .HPOS     (HPOS),
        .BLANK    (BLANK),
        .VID_AD   (VID_AD),
        .VID_DT   (VID_DT),
        .VID_RDY  (VID_RDY),
        .CPU_CS   (CPU_CS),
        .CPU_WR   (CPU_WR),
        .CPU_AD   (CPU_AD),
        .CPU_DI   (CPU_DI),
        .CPU_DO   (CPU_DO),
        .CPU_WAIT (CPU_WAIT),
        .RAM_AD   (RAM_AD),
        .RAM_WE   (RAM_WE),
        .RAM_DO   (RAM_DO),
        .RAM_DI   (RAM_DI)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // VRAM: registered read, write on RAM_WE & PCLK_EN.
    always @(posedge CLK) begin
        RAM_DI <= mem[RAM_AD];
        if (RAM_WE && PCLK_EN) begin
            mem[RAM_AD] = RAM_DO;
            we_cnt = we_cnt + 1;
        end
    end

    function automatic logic [DW-1:0] mem_init(input int a);
        return 8'((a * 29) ^ (a >> 7));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One pixel period; checks the video pipe and write protection after every pixel edge.
    task automatic pix();
        logic          vid_now;
        logic [AW-1:0] addr_now;
        repeat (3) tick();
        vid_now  = !BLANK && !HPOS[0];
        addr_now = VID_AD;
        PCLK_EN  = 1'b1;
        tick();
        PCLK_EN  = 1'b0;
        chk("vid_rdy", 32'(VID_RDY), 32'(prev_vid));
        if (prev_vid) exp_vid_dt = mem[prev_addr];
        chk("vid_dt", 32'(VID_DT), 32'(exp_vid_dt));
        chk("we_in_video_slot", 32'(RAM_WE && vid_now), 32'(0));
        if (vid_now) chk("ram_ad_video", 32'(RAM_AD), 32'(addr_now));
        prev_vid  = vid_now;
        prev_addr = addr_now;
        HPOS      = HPOS + 9'd1;
        VID_AD    = AW'(vid_base + int'(HPOS));
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = mem_init(i);
        RESET_N = 1'b0; PCLK_EN = 1'b0; HPOS = '0; BLANK = 1'b0; VID_AD = '0;
        CPU_CS = 1'b0; CPU_WR = 1'b0; CPU_AD = '0; CPU_DI = '0;
        prev_vid = 1'b0; prev_addr = '0; exp_vid_dt = '0;
        repeat (3) tick();

        chk("rst_ram_we", 32'(RAM_WE), 32'(0));
        chk("rst_ram_ad", 32'(RAM_AD), 32'(0));
        chk("rst_ram_do", 32'(RAM_DO), 32'(0));
        chk("rst_vid_dt", 32'(VID_DT), 32'(0));
        chk("rst_vid_rdy", 32'(VID_RDY), 32'(0));
        chk("rst_cpu_do", 32'(CPU_DO), 32'(0));
        chk("rst_wait_lo", 32'(CPU_WAIT), 32'(0));
        CPU_CS = 1'b1; #1;
        chk("rst_wait_follows_cs", 32'(CPU_WAIT), 32'(1));
        CPU_CS = 1'b0;
        RESET_N = 1'b1;
        tick();

        // Active line ramp, no CPU traffic
        vid_base = 'h100; HPOS = 9'd16; VID_AD = AW'(vid_base + 16);
        repeat (8) pix();
        chk("ramp_no_we", 32'(we_cnt), 32'(0));
        tick();
        chk("vid_rdy_one_clk", 32'(VID_RDY), 32'(0));

        // CPU write 0xA5 -> 0x0123 requested at even HPOS (24) in active display
        CPU_CS = 1'b1; CPU_WR = 1'b1; CPU_AD = 13'h0123; CPU_DI = 8'hA5; #1;
        chk("wr_wait_first_cycle", 32'(CPU_WAIT), 32'(1));
        pix();
        chk("wr_pend_wait", 32'(CPU_WAIT), 32'(1));
        chk("wr_pend_we", 32'(RAM_WE), 32'(0));
        pix();
        chk("wr_grant_we", 32'(RAM_WE), 32'(1));
        chk("wr_grant_ad", 32'(RAM_AD), 32'h0123);
        chk("wr_grant_do", 32'(RAM_DO), 32'hA5);
        chk("wr_grant_wait", 32'(CPU_WAIT), 32'(1));
        pix();
        chk("wr_done_we", 32'(RAM_WE), 32'(0));
        chk("wr_done_wait", 32'(CPU_WAIT), 32'(0));
        chk("wr_mem", 32'(mem[13'h0123]), 32'hA5);
        chk("wr_we_count", 32'(we_cnt), 32'(1));
        CPU_CS = 1'b0; #1;
        chk("wr_release_wait", 32'(CPU_WAIT), 32'(0));
        pix();

        // CPU read during blanking at even HPOS (28)
        BLANK = 1'b1;
        CPU_CS = 1'b1; CPU_WR = 1'b0; CPU_AD = 13'h0123;
        pix();
        chk("rd_grant_ad", 32'(RAM_AD), 32'h0123);
        chk("rd_grant_we", 32'(RAM_WE), 32'(0));
        chk("rd_grant_wait", 32'(CPU_WAIT), 32'(1));
        pix();
        chk("rd_data", 32'(CPU_DO), 32'hA5);
        chk("rd_done_wait", 32'(CPU_WAIT), 32'(0));
        CPU_CS = 1'b0;
        pix();
        chk("rd_data_held", 32'(CPU_DO), 32'hA5);

        // Back-to-back with CPU_CS held high
        CPU_CS = 1'b1; CPU_WR = 1'b1; CPU_AD = 13'h0200; CPU_DI = 8'h3C;
        pix();
        chk("b2b_first_we", 32'(RAM_WE), 32'(1));
        pix();
        chk("b2b_first_wait", 32'(CPU_WAIT), 32'(0));
        chk("b2b_first_mem", 32'(mem[13'h0200]), 32'h3C);
        CPU_AD = 13'h0201; CPU_DI = 8'h77;
        for (int i = 0; i < 3; i++) begin
            pix();
            chk("b2b_hold_we", 32'(RAM_WE), 32'(0));
            chk("b2b_hold_wait", 32'(CPU_WAIT), 32'(0));
        end
        chk("b2b_one_pulse", 32'(we_cnt), 32'(2));
        chk("b2b_no_second_write", 32'(mem[13'h0201]), 32'(mem_init('h201)));
        CPU_CS = 1'b0;
        pix();
        CPU_CS = 1'b1; #1;
        chk("b2b_new_req_wait", 32'(CPU_WAIT), 32'(1));
        pix();
        chk("b2b_second_we", 32'(RAM_WE), 32'(1));
        chk("b2b_second_ad", 32'(RAM_AD), 32'h0201);
        pix();
        chk("b2b_second_mem", 32'(mem[13'h0201]), 32'h77);
        chk("b2b_two_pulses", 32'(we_cnt), 32'(3));
        CPU_CS = 1'b0;
        pix();

        // Reset while a write sits in ACC
        CPU_CS = 1'b1; CPU_WR = 1'b1; CPU_AD = 13'h0300; CPU_DI = 8'h5A;
        pix();
        chk("rst_acc_we_before", 32'(RAM_WE), 32'(1));
        tick();
        RESET_N = 1'b0;
        tick();
        chk("rst_acc_we", 32'(RAM_WE), 32'(0));
        chk("rst_acc_ad", 32'(RAM_AD), 32'(0));
        chk("rst_acc_do", 32'(RAM_DO), 32'(0));
        chk("rst_acc_vid_dt", 32'(VID_DT), 32'(0));
        chk("rst_acc_vid_rdy", 32'(VID_RDY), 32'(0));
        chk("rst_acc_cpu_do", 32'(CPU_DO), 32'(0));
        chk("rst_acc_wait", 32'(CPU_WAIT), 32'(1));
        chk("rst_acc_write_dropped", 32'(mem[13'h0300]), 32'(mem_init('h300)));
        chk("rst_acc_we_count", 32'(we_cnt), 32'(3));
        prev_vid = 1'b0; exp_vid_dt = '0;
        RESET_N = 1'b1;
        tick();
        pix();
        chk("restart_we", 32'(RAM_WE), 32'(1));
        chk("restart_ad", 32'(RAM_AD), 32'h0300);
        chk("restart_wait", 32'(CPU_WAIT), 32'(1));
        pix();
        chk("restart_wait_done", 32'(CPU_WAIT), 32'(0));
        chk("restart_mem", 32'(mem[13'h0300]), 32'h5A);
        CPU_CS = 1'b0;
        pix();

        // HPOS wrap 511 -> 0 with a read pending
        BLANK = 1'b0; vid_base = 'h400; HPOS = 9'd509; VID_AD = AW'(vid_base + 509);
        pix();
        CPU_CS = 1'b1; CPU_WR = 1'b0; CPU_AD = 13'h0123;
        pix();
        chk("wrap_pend_wait", 32'(CPU_WAIT), 32'(1));
        chk("wrap_pend_we", 32'(RAM_WE), 32'(0));
        pix();
        chk("wrap_grant_ad", 32'(RAM_AD), 32'h0123);
        chk("wrap_grant_vid_rdy", 32'(VID_RDY), 32'(1));
        pix();
        chk("wrap_hpos0_video_ad", 32'(RAM_AD), 32'h0400);
        chk("wrap_rd_data", 32'(CPU_DO), 32'hA5);
        chk("wrap_wait_done", 32'(CPU_WAIT), 32'(0));
        pix();
        chk("wrap_vid_dt", 32'(VID_DT), 32'(mem_init('h400)));
        CPU_CS = 1'b0;
        pix();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
